// File: rtl/uart_tx_arb_if.sv
// rtl/uart_tx_arb_if.sv - requester, UART FIFO and status signals of the shared transmit arbiter
interface uart_tx_arb_if #(
    parameter int NREQ = 2,
    parameter int DBIT = 8
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DBIT-1:0] req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 tx_full;
    logic                 wr_uart;
    logic [DBIT-1:0]      w_data;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 abort_tick;

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, wr_uart, w_data, grant, busy, abort_tick
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, wr_uart, w_data, grant, busy, abort_tick
    );
endinterface

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one UART transmit FIFO among NREQ message sources
module uart_tx_arb #(
    parameter int NREQ    = 2,
    parameter int DBIT    = 8,
    parameter int TMO     = 255,
    parameter int TMO_BIT = 8
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_arb_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam logic [TMO_BIT-1:0] TMO_W = TMO_BIT'(TMO);

    typedef enum logic {IDLE, XFER} state_t;

    state_t             state;
    logic [NREQ-1:0]    grant_q;
    logic [IW-1:0]      gidx;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      scan_idx;
    logic               pick_found;
    logic [TMO_BIT-1:0] tmo_cnt;
    logic               busy_q;
    logic               abort_q;
    logic               g_valid;
    logic               g_last;
    logic [DBIT-1:0]    g_data;
    logic               xfer;
    logic               wr;

    // Round-robin search starts just after the last owner
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = IW'((int'(ptr) + k) % NREQ);
            if (!pick_found && bus.req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IW'(i)) begin
                g_valid = bus.req_valid[i];
                g_last  = bus.req_last[i];
                g_data  = bus.req_data[i*DBIT +: DBIT];
            end
        end
    end

    assign xfer = (state == XFER);
    assign wr   = xfer & g_valid & ~bus.tx_full;

    assign bus.wr_uart    = wr;
    assign bus.w_data     = wr ? g_data : '0;
    assign bus.req_ready  = grant_q & {NREQ{xfer & ~bus.tx_full}};
    assign bus.grant      = grant_q;
    assign bus.busy       = busy_q;
    assign bus.abort_tick = abort_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            grant_q <= '0;
            gidx    <= '0;
            ptr     <= IW'(NREQ - 1);
            tmo_cnt <= '0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state   <= XFER;
                        gidx    <= pick_idx;
                        grant_q <= NREQ'(1) << pick_idx;
                        tmo_cnt <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                XFER: begin
                    if (wr) begin
                        tmo_cnt <= '0;
                        if (g_last) begin
                            state   <= IDLE;
                            ptr     <= gidx;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else if (!g_valid) begin
                        // Only owner silence counts; FIFO stalls never time out
                        if (tmo_cnt >= TMO_W) begin
                            state   <= IDLE;
                            ptr     <= gidx;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            abort_q <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_BIT'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - self-checking bench for uart_tx_arb
module tb_uart_tx_arb;
    localparam int NREQ = 2;
    localparam int DBIT = 8;
    localparam int TMO  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;

    uart_tx_arb_if #(.NREQ(NREQ), .DBIT(DBIT)) bus ();

    uart_tx_arb #(.NREQ(NREQ), .DBIT(DBIT), .TMO(TMO), .TMO_BIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] valid;
        logic       full;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_wr;
        logic [7:0] exp_wd;
        logic [1:0] exp_ready;
    } vec_t;

    vec_t       vt [9];
    logic [7:0] got [$];
    int         wcyc [$];
    logic [7:0] exp_rr [8];
    int         idx [2];
    int         k;
    int         n_abort;

    int         m_own;
    int         m_ptr;
    int         m_idle;
    logic       m_abort;
    logic [1:0] rv;
    logic [1:0] rl;
    logic       rf;
    logic [7:0] rd0;
    logic [7:0] rd1;
    logic       e_wr;
    logic [7:0] e_wd;
    logic [1:0] e_ready;
    logic [1:0] e_grant;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [1:0] l, input logic f);
        bus.req_valid = v;
        bus.req_data  = {d1, d0};
        bus.req_last  = l;
        bus.tx_full   = f;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        vt[0] = '{2'b01, 1'b0, 8'h41, 8'h99, 1'b1, 8'h41, 2'b01};
        vt[1] = '{2'b11, 1'b0, 8'h42, 8'h55, 1'b1, 8'h42, 2'b01};
        vt[2] = '{2'b10, 1'b0, 8'h00, 8'h66, 1'b0, 8'h00, 2'b01};
        vt[3] = '{2'b11, 1'b1, 8'h43, 8'h77, 1'b0, 8'h00, 2'b00};
        vt[4] = '{2'b01, 1'b1, 8'h44, 8'h00, 1'b0, 8'h00, 2'b00};
        vt[5] = '{2'b00, 1'b0, 8'h45, 8'h88, 1'b0, 8'h00, 2'b01};
        vt[6] = '{2'b11, 1'b0, 8'h46, 8'hAA, 1'b1, 8'h46, 2'b01};
        vt[7] = '{2'b10, 1'b1, 8'h47, 8'hBB, 1'b0, 8'h00, 2'b00};
        vt[8] = '{2'b01, 1'b0, 8'h48, 8'hCC, 1'b1, 8'h48, 2'b01};
        exp_rr = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA0, 8'hA1, 8'hB0, 8'hB1};

        // Reset state
        drive(2'b11, 8'h11, 8'h22, 2'b00, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_abort", bus.abort_tick, 0);
        chk("rst_wr", bus.wr_uart, 0);
        chk("rst_ready", bus.req_ready, 0);
        reset = 1'b1;

        // Single 3-byte message from requester 0
        do_reset();
        @(negedge clk);
        drive(2'b01, 8'h41, 8'h00, 2'b00, 1'b0);
        #1;
        chk("single_arb_wr", bus.wr_uart, 0);
        chk("single_arb_ready", bus.req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(2'b01, 8'(8'h41 + i), 8'h00, {1'b0, i == 2}, 1'b0);
            #1;
            chk($sformatf("single_grant%0d", i), bus.grant, 2'b01);
            chk($sformatf("single_wr%0d", i), bus.wr_uart, 1);
            chk($sformatf("single_data%0d", i), bus.w_data, 8'(8'h41 + i));
        end
        @(negedge clk);
        drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
        #1;
        chk("single_end_grant", bus.grant, 0);
        chk("single_end_busy", bus.busy, 0);

        // Vector table inside a requester-0 message, requester 1 toggling
        do_reset();
        @(negedge clk);
        drive(2'b01, 8'h40, 8'h00, 2'b00, 1'b0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vt[i].valid, vt[i].d0, vt[i].d1, 2'b00, vt[i].full);
            #1;
            chk($sformatf("vec%0d_wr", i), bus.wr_uart, vt[i].exp_wr);
            chk($sformatf("vec%0d_wdata", i), bus.w_data, vt[i].exp_wd);
            chk($sformatf("vec%0d_ready", i), bus.req_ready, vt[i].exp_ready);
            chk($sformatf("vec%0d_grant", i), bus.grant, 2'b01);
            chk($sformatf("vec%0d_busy", i), bus.busy, 1);
        end

        // Round robin with both requesters always valid
        do_reset();
        got.delete();
        wcyc.delete();
        idx = '{0, 0};
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive(2'b11, 8'(8'hA0 + idx[0]), 8'(8'hB0 + idx[1]), {idx[1] == 1, idx[0] == 1}, 1'b0);
            #1;
            if (bus.wr_uart) begin
                got.push_back(bus.w_data);
                wcyc.push_back(c);
            end
            for (int r = 0; r < 2; r++)
                if (bus.req_ready[r]) idx[r] = 1 - idx[r];
        end
        chk("rr_count_ge8", 32'(got.size() >= 8), 1);
        if (got.size() >= 8) begin
            for (int i = 0; i < 8; i++) chk($sformatf("rr_byte%0d", i), got[i], exp_rr[i]);
            chk("rr_in_msg_gap", 32'(wcyc[1] - wcyc[0]), 1);
            chk("rr_msg_gap", 32'(wcyc[2] - wcyc[1]), 2);
        end

        // Backpressure for 10 cycles mid-message
        do_reset();
        got.delete();
        k = 0;
        n_abort = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive({1'b0, k < 4}, 8'(8'h10 + k), 8'h00, {1'b0, k == 3}, (c >= 4 && c < 14));
            #1;
            if (c >= 4 && c < 14) begin
                chk($sformatf("bp_wr_c%0d", c), bus.wr_uart, 0);
                chk($sformatf("bp_ready_c%0d", c), bus.req_ready[0], 0);
            end
            if (c == 14) begin
                chk("bp_resume_wr", bus.wr_uart, 1);
                chk("bp_resume_data", bus.w_data, 8'h13);
            end
            if (bus.abort_tick) n_abort++;
            if (bus.wr_uart) got.push_back(bus.w_data);
            if (bus.req_ready[0] && k < 4) k++;
        end
        chk("bp_abort_count", n_abort, 0);
        chk("bp_byte_count", got.size(), 4);
        if (got.size() == 4)
            for (int i = 0; i < 4; i++) chk($sformatf("bp_byte%0d", i), got[i], 8'(8'h10 + i));

        // Timeout: requester 1 sends one byte then goes silent
        do_reset();
        n_abort = 0;
        @(negedge clk);
        drive(2'b10, 8'h00, 8'h77, 2'b00, 1'b0);
        @(negedge clk);
        #1;
        chk("to_first_wr", bus.wr_uart, 1);
        chk("to_first_data", bus.w_data, 8'h77);
        chk("to_first_grant", bus.grant, 2'b10);
        for (int c = 2; c < 10; c++) begin
            @(negedge clk);
            drive({1'b0, c >= 5}, 8'h5A, 8'h00, 2'b01, 1'b0);
            #1;
            chk($sformatf("to_abort_c%0d", c), bus.abort_tick, (c == 7));
            chk($sformatf("to_grant_c%0d", c), bus.grant,
                (c < 7) ? 2'b10 : (c == 8) ? 2'b01 : 2'b00);
            chk($sformatf("to_wr_c%0d", c), bus.wr_uart, (c == 8));
            if (bus.abort_tick) n_abort++;
        end
        chk("to_abort_count", n_abort, 1);

        // Reset during the second byte of a 3-byte message
        do_reset();
        @(negedge clk);
        drive(2'b01, 8'h61, 8'h00, 2'b00, 1'b0);
        @(negedge clk);
        drive(2'b01, 8'h61, 8'h00, 2'b00, 1'b0);
        @(negedge clk);
        drive(2'b01, 8'h62, 8'h00, 2'b00, 1'b0);
        #1;
        chk("rm_second_wr", bus.wr_uart, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("rm_grant", bus.grant, 0);
        chk("rm_busy", bus.busy, 0);
        chk("rm_wr", bus.wr_uart, 0);
        chk("rm_ready", bus.req_ready, 0);
        chk("rm_abort", bus.abort_tick, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(2'b11, 8'h71, 8'h81, 2'b11, 1'b0);
        @(negedge clk);
        #1;
        chk("rm_regrant", bus.grant, 2'b01);
        chk("rm_regrant_data", bus.w_data, 8'h71);
        chk("rm_no_abort", bus.abort_tick, 0);

        // Random traffic against a message-level reference model
        do_reset();
        m_own   = -1;
        m_ptr   = NREQ - 1;
        m_idle  = 0;
        m_abort = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                rv[r] = ($urandom_range(0, 9) < 7);
                rl[r] = ($urandom_range(0, 9) < 3);
            end
            rf  = ($urandom_range(0, 9) < 2);
            rd0 = 8'($urandom);
            rd1 = 8'($urandom);
            drive(rv, rd0, rd1, rl, rf);
            #1;
            if (m_own < 0) begin
                e_wr = 1'b0; e_wd = 8'h00; e_ready = 2'b00; e_grant = 2'b00;
            end else begin
                e_grant = 2'(1 << m_own);
                e_ready = rf ? 2'b00 : e_grant;
                e_wr    = rv[m_own] && !rf;
                e_wd    = e_wr ? ((m_own == 0) ? rd0 : rd1) : 8'h00;
            end
            chk($sformatf("rnd%0d_wr", c), bus.wr_uart, e_wr);
            chk($sformatf("rnd%0d_wdata", c), bus.w_data, e_wd);
            chk($sformatf("rnd%0d_ready", c), bus.req_ready, e_ready);
            chk($sformatf("rnd%0d_grant", c), bus.grant, e_grant);
            chk($sformatf("rnd%0d_busy", c), bus.busy, (m_own >= 0));
            chk($sformatf("rnd%0d_abort", c), bus.abort_tick, m_abort);
            m_abort = 1'b0;
            if (m_own < 0) begin
                for (int s = 1; s <= NREQ; s++) begin
                    if (m_own < 0 && rv[(m_ptr + s) % NREQ]) begin
                        m_own  = (m_ptr + s) % NREQ;
                        m_idle = 0;
                    end
                end
            end else if (e_wr) begin
                m_idle = 0;
                if (rl[m_own]) begin
                    m_ptr = m_own;
                    m_own = -1;
                end
            end else if (!rv[m_own]) begin
                if (m_idle >= TMO) begin
                    m_abort = 1'b1;
                    m_ptr   = m_own;
                    m_own   = -1;
                end else begin
                    m_idle++;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
